// File: rtl/unidade_controle_jogo_exp7_if.sv
// Control/status bundle between the memory-game FSM and its datapath.
// master = FSM side, slave = datapath/top side.
interface unidade_controle_jogo_exp7_if;
  logic       iniciar;
  logic       jogada;
  logic       igual;
  logic       enderecoIgualRodada;
  logic       fimRodada;
  logic       fimMostra;
  logic       timeout;
  logic       zeraE;
  logic       contaE;
  logic       zeraR;
  logic       contaR;
  logic       registraR;
  logic       escreveM;
  logic       zeraT;
  logic       contaT;
  logic       zeraM;
  logic       contaM;
  logic       mostraLed;
  logic       pronto;
  logic       ganhou;
  logic       perdeu;
  logic       db_timeout;
  logic [3:0] db_estado;

  modport master (
    input  iniciar, jogada, igual,
    input  enderecoIgualRodada,
    input  fimRodada, fimMostra, timeout,
    output zeraE, contaE, zeraR, contaR,
    output registraR, escreveM,
    output zeraT, contaT, zeraM, contaM,
    output mostraLed, pronto, ganhou,
    output perdeu, db_timeout, db_estado
  );

  modport slave (
    output iniciar, jogada, igual,
    output enderecoIgualRodada,
    output fimRodada, fimMostra, timeout,
    input  zeraE, contaE, zeraR, contaR,
    input  registraR, escreveM,
    input  zeraT, contaT, zeraM, contaM,
    input  mostraLed, pronto, ganhou,
    input  perdeu, db_timeout, db_estado
  );
endinterface

// File: rtl/unidade_controle_jogo_exp7.sv
// Moore control FSM for the memory game: replay the stored
// sequence each round, then record one new play.
module unidade_controle_jogo_exp7 #(
  parameter bit TIMEOUT_EN  = 1'b1,
  parameter bit REINICIA_EN = 1'b1
) (
  input logic clock,
  input logic reset,
  unidade_controle_jogo_exp7_if.master bus
);

  typedef enum logic [3:0] {
    INICIAL        = 4'h0,
    PREPARACAO     = 4'h1,
    MOSTRA_INICIAL = 4'h2,
    INICIA_RODADA  = 4'h3,
    ESPERA_JOGADA  = 4'h4,
    REGISTRA       = 4'h5,
    COMPARA        = 4'h6,
    PROXIMA_JOGADA = 4'h7,
    FIM_RODADA     = 4'h8,
    ESPERA_NOVA    = 4'h9,
    REGISTRA_NOVA  = 4'hA,
    FIM_GANHOU     = 4'hB,
    FIM_PERDEU     = 4'hC,
    FIM_TIMEOUT    = 4'hD,
    ESCREVE_NOVA   = 4'hE,
    NAO_USADO      = 4'hF
  } estado_t;

  estado_t estado_q;
  estado_t estado_d;

  logic perde_tempo;
  logic reinicia;

  assign perde_tempo = bus.timeout & TIMEOUT_EN;
  assign reinicia    = bus.iniciar & REINICIA_EN;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) estado_q <= INICIAL;
    else        estado_q <= estado_d;
  end

  // jogada wins over timeout in both wait states
  always_comb begin
    estado_d = estado_q;
    unique case (estado_q)
      INICIAL:
        if (bus.iniciar) estado_d = PREPARACAO;
      PREPARACAO:
        estado_d = MOSTRA_INICIAL;
      MOSTRA_INICIAL:
        if (bus.fimMostra) estado_d = INICIA_RODADA;
      INICIA_RODADA:
        estado_d = ESPERA_JOGADA;
      ESPERA_JOGADA:
        if (bus.jogada)   estado_d = REGISTRA;
        else if (perde_tempo) estado_d = FIM_TIMEOUT;
      REGISTRA:
        estado_d = COMPARA;
      COMPARA:
        if (!bus.igual)
          estado_d = FIM_PERDEU;
        else if (bus.enderecoIgualRodada)
          estado_d = FIM_RODADA;
        else
          estado_d = PROXIMA_JOGADA;
      PROXIMA_JOGADA:
        estado_d = ESPERA_JOGADA;
      FIM_RODADA:
        estado_d = bus.fimRodada ? FIM_GANHOU
                                 : ESPERA_NOVA;
      ESPERA_NOVA:
        if (bus.jogada)   estado_d = REGISTRA_NOVA;
        else if (perde_tempo) estado_d = FIM_TIMEOUT;
      REGISTRA_NOVA:
        estado_d = ESCREVE_NOVA;
      ESCREVE_NOVA:
        estado_d = INICIA_RODADA;
      FIM_GANHOU, FIM_PERDEU, FIM_TIMEOUT:
        if (reinicia) estado_d = PREPARACAO;
      NAO_USADO:
        estado_d = INICIAL;
      default:
        estado_d = INICIAL;
    endcase
  end

  always_comb begin
    bus.zeraE      = 1'b0;
    bus.contaE     = 1'b0;
    bus.zeraR      = 1'b0;
    bus.contaR     = 1'b0;
    bus.registraR  = 1'b0;
    bus.escreveM   = 1'b0;
    bus.zeraT      = 1'b0;
    bus.contaT     = 1'b0;
    bus.zeraM      = 1'b0;
    bus.contaM     = 1'b0;
    bus.mostraLed  = 1'b0;
    bus.pronto     = 1'b0;
    bus.ganhou     = 1'b0;
    bus.perdeu     = 1'b0;
    bus.db_timeout = 1'b0;
    bus.db_estado  = estado_q;
    unique case (estado_q)
      PREPARACAO: begin
        bus.zeraE = 1'b1;
        bus.zeraR = 1'b1;
        bus.zeraT = 1'b1;
        bus.zeraM = 1'b1;
      end
      MOSTRA_INICIAL: begin
        bus.mostraLed = 1'b1;
        bus.contaM    = 1'b1;
      end
      INICIA_RODADA: begin
        bus.zeraE = 1'b1;
        bus.zeraT = 1'b1;
      end
      ESPERA_JOGADA, ESPERA_NOVA:
        bus.contaT = 1'b1;
      REGISTRA: begin
        bus.registraR = 1'b1;
        bus.zeraT     = 1'b1;
      end
      PROXIMA_JOGADA:
        bus.contaE = 1'b1;
      FIM_RODADA:
        bus.zeraT = 1'b1;
      REGISTRA_NOVA: begin
        bus.registraR = 1'b1;
        bus.contaE    = 1'b1;
        bus.zeraT     = 1'b1;
      end
      ESCREVE_NOVA: begin
        bus.escreveM = 1'b1;
        bus.contaR   = 1'b1;
      end
      FIM_GANHOU: begin
        bus.pronto = 1'b1;
        bus.ganhou = 1'b1;
      end
      FIM_PERDEU: begin
        bus.pronto = 1'b1;
        bus.perdeu = 1'b1;
      end
      FIM_TIMEOUT: begin
        bus.pronto     = 1'b1;
        bus.perdeu     = 1'b1;
        bus.db_timeout = 1'b1;
      end
      INICIAL, COMPARA, NAO_USADO: ;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_unidade_controle_jogo_exp7.sv
// Bench for the memory-game control FSM: directed table, corner
// sequences and random stimulus against a rule-level model.
module tb_unidade_controle_jogo_exp7;

  typedef struct packed {
    logic ini, jog, ig, eq, fr, fm, to;
  } in_t;

  typedef struct {
    in_t in;
    int  exp_s;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  in_t  cur;
  int   n_pass = 0;
  int   n_tot  = 0;

  always #5 clk = ~clk;

  unidade_controle_jogo_exp7_if b0 ();
  unidade_controle_jogo_exp7_if b1 ();
  unidade_controle_jogo_exp7_if b2 ();

  unidade_controle_jogo_exp7 #(.TIMEOUT_EN(1'b1), .REINICIA_EN(1'b1))
    dut0 (.clock(clk), .reset(rst_n), .bus(b0));
  unidade_controle_jogo_exp7 #(.TIMEOUT_EN(1'b1), .REINICIA_EN(1'b0))
    dut1 (.clock(clk), .reset(rst_n), .bus(b1));
  unidade_controle_jogo_exp7 #(.TIMEOUT_EN(1'b0), .REINICIA_EN(1'b1))
    dut2 (.clock(clk), .reset(rst_n), .bus(b2));

  assign b0.iniciar = cur.ini; assign b0.jogada = cur.jog;
  assign b0.igual = cur.ig; assign b0.enderecoIgualRodada = cur.eq;
  assign b0.fimRodada = cur.fr; assign b0.fimMostra = cur.fm;
  assign b0.timeout = cur.to;
  assign b1.iniciar = cur.ini; assign b1.jogada = cur.jog;
  assign b1.igual = cur.ig; assign b1.enderecoIgualRodada = cur.eq;
  assign b1.fimRodada = cur.fr; assign b1.fimMostra = cur.fm;
  assign b1.timeout = cur.to;
  assign b2.iniciar = cur.ini; assign b2.jogada = cur.jog;
  assign b2.igual = cur.ig; assign b2.enderecoIgualRodada = cur.eq;
  assign b2.fimRodada = cur.fr; assign b2.fimMostra = cur.fm;
  assign b2.timeout = cur.to;

  logic [18:0] obs [3];
  assign obs[0] = {b0.zeraE, b0.contaE, b0.zeraR, b0.contaR,
    b0.registraR, b0.escreveM, b0.zeraT, b0.contaT, b0.zeraM,
    b0.contaM, b0.mostraLed, b0.pronto, b0.ganhou, b0.perdeu,
    b0.db_timeout, b0.db_estado};
  assign obs[1] = {b1.zeraE, b1.contaE, b1.zeraR, b1.contaR,
    b1.registraR, b1.escreveM, b1.zeraT, b1.contaT, b1.zeraM,
    b1.contaM, b1.mostraLed, b1.pronto, b1.ganhou, b1.perdeu,
    b1.db_timeout, b1.db_estado};
  assign obs[2] = {b2.zeraE, b2.contaE, b2.zeraR, b2.contaR,
    b2.registraR, b2.escreveM, b2.zeraT, b2.contaT, b2.zeraM,
    b2.contaM, b2.mostraLed, b2.pronto, b2.ganhou, b2.perdeu,
    b2.db_timeout, b2.db_estado};

  // Bit order: zeraE contaE zeraR contaR registraR escreveM zeraT
  // contaT zeraM contaM mostraLed pronto ganhou perdeu db_timeout
  function automatic logic [14:0] omask(input int s);
    case (s)
      1:  return 15'b101000101000000;
      2:  return 15'b000000000110000;
      3:  return 15'b100000100000000;
      4:  return 15'b000000010000000;
      5:  return 15'b000010100000000;
      7:  return 15'b010000000000000;
      8:  return 15'b000000100000000;
      9:  return 15'b000000010000000;
      10: return 15'b010010100000000;
      11: return 15'b000000000001100;
      12: return 15'b000000000001010;
      13: return 15'b000000000001011;
      14: return 15'b000101000000000;
      default: return 15'b0;
    endcase
  endfunction

  function automatic int nxt(input int s, input in_t v,
                             input bit ten, input bit ren);
    if (s == 11 || s == 12 || s == 13)
      return (v.ini && ren) ? 1 : s;
    if (s == 4 || s == 9) begin
      if (v.jog) return (s == 4) ? 5 : 10;
      if (v.to && ten) return 13;
      return s;
    end
    case (s)
      0:  return v.ini ? 1 : 0;
      1:  return 2;
      2:  return v.fm ? 3 : 2;
      3:  return 4;
      5:  return 6;
      6:  return !v.ig ? 12 : (v.eq ? 8 : 7);
      7:  return 4;
      8:  return v.fr ? 11 : 9;
      10: return 14;
      14: return 3;
      default: return 0;
    endcase
  endfunction

  function automatic in_t mk(input bit ini, jog, ig, eq,
                             input bit fr, fm, to);
    in_t v;
    v = '{ini, jog, ig, eq, fr, fm, to};
    return v;
  endfunction

  task automatic chk(input string nm, input int k, input int es);
    logic [18:0] e;
    logic [3:0]  s4;
    s4 = 4'(es);
    e = {omask(es), s4};
    n_tot++;
    if (obs[k] === e) n_pass++;
    else $display("FAIL %s dut%0d: got %h want %h (t=%0t)",
                  nm, k, obs[k], e, $time);
  endtask

  task automatic step(input in_t v);
    cur = v;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    cur = '0;
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) chk("reset", k, 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  vec_t tv[$];
  in_t  nn;
  int   ms [3];
  bit   ten_k [3] = '{1'b1, 1'b1, 1'b0};
  bit   ren_k [3] = '{1'b1, 1'b0, 1'b1};

  initial begin
    nn = '0;
    cur = '0;
    rst_n = 1'b0;
    #12;
    for (int k = 0; k < 3; k++) chk("reset_init", k, 0);

    tv.push_back('{mk(1,0,0,0,0,0,0), 1});
    tv.push_back('{nn, 2});
    tv.push_back('{nn, 2});
    tv.push_back('{mk(0,0,0,0,0,1,0), 3});
    tv.push_back('{nn, 4});
    tv.push_back('{nn, 4});
    tv.push_back('{mk(0,1,0,0,0,0,0), 5});
    tv.push_back('{nn, 6});
    tv.push_back('{mk(0,0,1,1,0,0,0), 8});
    tv.push_back('{nn, 9});
    tv.push_back('{mk(0,1,0,0,0,0,0), 10});
    tv.push_back('{nn, 14});
    tv.push_back('{nn, 3});
    tv.push_back('{nn, 4});
    tv.push_back('{mk(0,1,0,0,0,0,0), 5});
    tv.push_back('{nn, 6});
    tv.push_back('{mk(0,0,1,0,0,0,0), 7});
    tv.push_back('{nn, 4});
    tv.push_back('{mk(0,1,0,0,0,0,0), 5});
    tv.push_back('{nn, 6});
    tv.push_back('{mk(0,0,0,1,0,0,0), 12});
    for (int i = 0; i < 100; i++) tv.push_back('{nn, 12});
    tv.push_back('{mk(1,0,0,0,0,0,0), 1});
    tv.push_back('{nn, 2});
    tv.push_back('{mk(0,0,0,0,0,1,0), 3});
    tv.push_back('{nn, 4});
    tv.push_back('{mk(0,1,0,0,0,0,0), 5});
    tv.push_back('{nn, 6});
    tv.push_back('{mk(0,0,1,1,0,0,0), 8});
    tv.push_back('{mk(0,0,0,0,1,0,0), 11});
    tv.push_back('{nn, 11});
    tv.push_back('{mk(1,0,0,0,0,0,0), 1});
    tv.push_back('{nn, 2});
    tv.push_back('{mk(0,0,0,0,0,1,0), 3});
    tv.push_back('{nn, 4});
    tv.push_back('{mk(0,0,0,0,0,0,1), 13});
    tv.push_back('{nn, 13});
    tv.push_back('{mk(1,0,0,0,0,0,0), 1});
    tv.push_back('{nn, 2});
    tv.push_back('{mk(0,0,0,0,0,1,0), 3});
    tv.push_back('{nn, 4});
    tv.push_back('{mk(0,1,0,0,0,0,1), 5});

    @(negedge clk);
    rst_n = 1'b1;
    foreach (tv[i]) begin
      step(tv[i].in);
      chk($sformatf("table[%0d]", i), 0, tv[i].exp_s);
    end

    // win state: REINICIA_EN=0 instance must stay in fim_ganhou
    do_reset();
    step(mk(1,0,0,0,0,0,0)); step(nn);
    step(mk(0,0,0,0,0,1,0)); step(nn);
    step(mk(0,1,0,0,0,0,0)); step(nn);
    step(mk(0,0,1,1,0,0,0));
    step(mk(0,0,0,0,1,0,0));
    for (int k = 0; k < 3; k++) chk("win", k, 11);
    step(mk(1,0,0,0,0,0,0));
    chk("restart", 0, 1);
    chk("no_restart", 1, 11);
    chk("restart", 2, 1);
    step(nn);
    chk("no_restart_hold", 1, 11);

    // timeout: TIMEOUT_EN=0 instance keeps waiting
    do_reset();
    step(mk(1,0,0,0,0,0,0)); step(nn);
    step(mk(0,0,0,0,0,1,0)); step(nn);
    step(mk(0,0,0,0,0,0,1));
    chk("timeout", 0, 13);
    chk("timeout", 1, 13);
    chk("timeout_off", 2, 4);
    step(mk(0,0,0,0,0,0,1));
    chk("timeout_off_hold", 2, 4);
    step(mk(0,1,0,0,0,0,0));
    chk("timeout_off_play", 2, 5);

    // asynchronous reset while waiting for the new play
    do_reset();
    step(mk(1,0,0,0,0,0,0)); step(nn);
    step(mk(0,0,0,0,0,1,0)); step(nn);
    step(mk(0,1,0,0,0,0,0)); step(nn);
    step(mk(0,0,1,1,0,0,0));
    step(nn);
    chk("espera_nova", 0, 9);
    #1 rst_n = 1'b0;
    #1 chk("async_reset", 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(mk(1,0,0,0,0,0,0));
    chk("after_reset", 0, 1);
    step(nn);
    chk("after_reset2", 0, 2);

    do_reset();
    for (int k = 0; k < 3; k++) ms[k] = 0;
    for (int n = 0; n < 3000; n++) begin
      in_t v;
      v.ini = ($urandom_range(0, 15) == 0);
      v.jog = ($urandom_range(0, 3) == 0);
      v.ig  = ($urandom_range(0, 4) != 0);
      v.eq  = ($urandom_range(0, 1) == 0);
      v.fr  = ($urandom_range(0, 3) == 0);
      v.fm  = ($urandom_range(0, 2) == 0);
      v.to  = ($urandom_range(0, 7) == 0);
      for (int k = 0; k < 3; k++)
        ms[k] = nxt(ms[k], v, ten_k[k], ren_k[k]);
      step(v);
      for (int k = 0; k < 3; k++) chk("random", k, ms[k]);
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/unidade_controle_jogo_exp7.md
Name: unidade_controle_jogo_exp7

Overview:
Moore FSM that sequences the memory-game datapath (address/round counters, sequence memory, button register, timeout and display timers).
- Each round: the player repeats the stored sequence, then enters one new play, which is written to memory.
- Sits between top-level inputs (iniciar) and the datapath.
- Drives datapath control strobes and the status outputs pronto/ganhou/perdeu.

Parameters:
TIMEOUT_EN, 1, 1 = timeout input ends game as loss; 0 = timeout ignored
REINICIA_EN, 1, 1 = iniciar in a terminal state restarts the game; 0 = only reset leaves terminal states

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
iniciar  in  1  start request, level
jogada  in  1  one-cycle pulse from datapath edge detector: button pressed
igual  in  1  registered button equals memory[address]
enderecoIgualRodada  in  1  address counter == round counter
fimRodada  in  1  round counter at last round
fimMostra  in  1  display timer expired
timeout  in  1  play timer expired
zeraE  out  1  clear address counter
contaE  out  1  increment address counter
zeraR  out  1  clear round counter
contaR  out  1  increment round counter
registraR  out  1  load button register
escreveM  out  1  write button register into memory[address]
zeraT  out  1  clear play timer
contaT  out  1  enable play timer
zeraM  out  1  clear display timer
contaM  out  1  enable display timer
mostraLed  out  1  leds show memory[address]
pronto  out  1  game finished
ganhou  out  1  game won
perdeu  out  1  game lost (wrong play or timeout)
db_timeout  out  1  loss caused by timeout
db_estado  out  4  current state code

Behaviour:
- State register: 4 bits. Outputs are pure functions of state (Moore). Transitions occur on the rising edge of clock.
- reset low: state forced to inicial (0) immediately, independent of clock. While in inicial, every output is 0 and db_estado = 0.
- States, their asserted outputs, and next-state rules:
  - 0 inicial: no outputs asserted. iniciar=1 -> 1.
  - 1 preparacao: zeraE, zeraR, zeraT, zeraM. Always -> 2.
  - 2 mostra_inicial: mostraLed, contaM. fimMostra -> 3; else stay.
  - 3 inicia_rodada: zeraE, zeraT. Always -> 4.
  - 4 espera_jogada: contaT. jogada -> 5; else timeout & TIMEOUT_EN -> D; else stay.
  - 5 registra: registraR, zeraT. Always -> 6.
  - 6 compara: no outputs. !igual -> C; igual & enderecoIgualRodada -> 8; igual & !enderecoIgualRodada -> 7.
  - 7 proxima_jogada: contaE. Always -> 4.
  - 8 fim_rodada: zeraT. fimRodada -> B; else -> 9.
  - 9 espera_nova: contaT. jogada -> A; else timeout & TIMEOUT_EN -> D; else stay.
  - A registra_nova: registraR, contaE, zeraT. Always -> E.
  - E escreve_nova: escreveM, contaR. Always -> 3.
  - B fim_ganhou: pronto, ganhou.
  - C fim_perdeu: pronto, perdeu.
  - D fim_timeout: pronto, perdeu, db_timeout.
  - F: unused; -> 0.
- Terminal states B/C/D: iniciar & REINICIA_EN -> 1; else stay.
- Priority: jogada beats timeout in the same cycle (4, 9).
- iniciar is ignored in states 1–A and E.
- Latency: iniciar high at an edge in state 0 -> preparacao on that edge. A jogada pulse in state 4 -> compara two edges later.
- Reset asserted mid-game: returns to inicial at once, all strobes drop asynchronously. Sequence memory contents are not touched.
- Exactly one of pronto-related state groups is active at a time. ganhou and perdeu are never both 1.

Test Plan:
- Reset low, iniciar=0 -> db_estado=0, all outputs 0. iniciar high 1 cycle -> state 1 for exactly 1 cycle with zeraE/zeraR/zeraT/zeraM, then state 2 with mostraLed=1 until fimMostra.
- Round 1 win path (fimRodada=0), new play entered -> state sequence 3,4,5,6,8,9,A,E,3. escreveM and contaR high exactly 1 cycle in E.
- Round 2: first play igual=1, enderecoIgualRodada=0 -> 7 (contaE 1 cycle) -> 4. Second play igual=0 -> C: pronto=1, perdeu=1, ganhou=0, held 100 cycles.
- fimRodada=1 after final correct play -> B: pronto=1, ganhou=1. iniciar=1 -> state 1 (REINICIA_EN=1). With REINICIA_EN=0 -> stays B.
- In state 4: timeout=1 -> D with perdeu=1, db_timeout=1. jogada and timeout same cycle -> 5. TIMEOUT_EN=0 with timeout=1 -> stays 4.
- Reset pulled low while in state 9 -> db_estado=0 and contaT=0 before next clock edge. Release, then iniciar -> normal restart.
